anabellek_hakem: RTL

Two-port arbiter that shares the single main-memory (`anabellek`) line interface between two cache requesters (port 0: instruction cache, port 1: data cache). It accepts one line request at a time, registers it, forwards it to memory, and routes the read response back to the owning port. Fairness is round-robin, and only one transaction is outstanding at a time. It sits between the two `onbellek` instances and `anabellek`.

---
 rtl/anabellek_hakem.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/anabellek_hakem.sv
// anabellek_hakem: round-robin arbiter sharing one main-memory line port
// between the instruction cache (port 0) and the data cache (port 1).
//
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   pX_istek_*                  line request from cache X (addr/data/valid/write)
//   pX_istek_hazir_o            request accepted this cycle (combinational)
//   pX_yanit_*                  read response to cache X (data/valid/ready)
//   anabellek_istek_*           registered request towards memory
//   anabellek_yanit_*           read response from memory
module anabellek_hakem #(
  parameter int unsigned ADRES_BIT = 32,
  parameter int unsigned VERI_BIT  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ADRES_BIT-1:0] p0_istek_adres_i,
  input  logic [VERI_BIT-1:0]  p0_istek_veri_i,
  input  logic                 p0_istek_gecerli_i,
  input  logic                 p0_istek_yaz_gecerli_i,
  output logic                 p0_istek_hazir_o,
  output logic [VERI_BIT-1:0]  p0_yanit_veri_o,
  output logic                 p0_yanit_gecerli_o,
  input  logic                 p0_yanit_hazir_i,
  input  logic [ADRES_BIT-1:0] p1_istek_adres_i,
  input  logic [VERI_BIT-1:0]  p1_istek_veri_i,
  input  logic                 p1_istek_gecerli_i,
  input  logic                 p1_istek_yaz_gecerli_i,
  output logic                 p1_istek_hazir_o,
  output logic [VERI_BIT-1:0]  p1_yanit_veri_o,
  output logic                 p1_yanit_gecerli_o,
  input  logic                 p1_yanit_hazir_i,
  output logic [ADRES_BIT-1:0] anabellek_istek_adres_o,
  output logic [VERI_BIT-1:0]  anabellek_istek_veri_o,
  output logic                 anabellek_istek_gecerli_o,
  output logic                 anabellek_istek_yaz_gecerli_o,
  input  logic                 anabellek_istek_hazir_i,
  input  logic [VERI_BIT-1:0]  anabellek_yanit_veri_i,
  input  logic                 anabellek_yanit_gecerli_i,
  output logic                 anabellek_yanit_hazir_o
);

  typedef enum logic [1:0] {
    BOSTA,
    ISTEK,
    YANIT
  } durum_t;

  durum_t               durum;
  durum_t               durum_n;
  logic                 sahip;
  logic                 son_sahip;
  logic [ADRES_BIT-1:0] adres_r;
  logic [VERI_BIT-1:0]  veri_r;
  logic                 yaz_r;

  logic kazanan;
  logic istek_var;
  logic kabul;
  logic sahip_hazir;
  logic yanit_aktif;
  logic el_sikisma;

  assign istek_var = p0_istek_gecerli_i | p1_istek_gecerli_i;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    kazanan = 1'b0;
    unique case (1'b1)
      (p0_istek_gecerli_i & p1_istek_gecerli_i):
        kazanan = ~son_sahip;
      (p1_istek_gecerli_i & ~p0_istek_gecerli_i):
        kazanan = 1'b1;
      default:
        kazanan = 1'b0;
    endcase
  end

  // rst_ni gates acceptance so every output is 0 while reset is held.
  assign kabul = rst_ni & (durum == BOSTA) & istek_var;

  assign p0_istek_hazir_o = kabul & ~kazanan;
  assign p1_istek_hazir_o = kabul & kazanan;

  assign yanit_aktif = (durum == YANIT);
  assign sahip_hazir = sahip ? p1_yanit_hazir_i
                             : p0_yanit_hazir_i;
  assign el_sikisma  = anabellek_yanit_gecerli_i
                     & sahip_hazir;

  always_comb begin
    durum_n = durum;
    unique case (durum)
      BOSTA: begin
        if (istek_var) durum_n = ISTEK;
      end
      ISTEK: begin
        if (anabellek_istek_hazir_i)
          durum_n = yaz_r ? BOSTA : YANIT;
      end
      YANIT: begin
        if (el_sikisma) durum_n = BOSTA;
      end
      default: durum_n = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum     <= BOSTA;
      sahip     <= 1'b0;
      son_sahip <= 1'b1;
      adres_r   <= '0;
      veri_r    <= '0;
      yaz_r     <= 1'b0;
    end else begin
      durum <= durum_n;
      if (kabul) begin
        sahip     <= kazanan;
        son_sahip <= kazanan;
        adres_r   <= kazanan ? p1_istek_adres_i
                             : p0_istek_adres_i;
        veri_r    <= kazanan ? p1_istek_veri_i
                             : p0_istek_veri_i;
        yaz_r     <= kazanan ? p1_istek_yaz_gecerli_i
                             : p0_istek_yaz_gecerli_i;
      end
    end
  end

  assign anabellek_istek_gecerli_o     = (durum == ISTEK);
  assign anabellek_istek_adres_o       = adres_r;
  assign anabellek_istek_veri_o        = veri_r;
  assign anabellek_istek_yaz_gecerli_o = yaz_r
                                       & (durum == ISTEK);

  // Memory responses outside YANIT are neither accepted nor forwarded.
  assign anabellek_yanit_hazir_o = yanit_aktif & sahip_hazir;

  assign p0_yanit_gecerli_o = yanit_aktif & ~sahip
                            & anabellek_yanit_gecerli_i;
  assign p1_yanit_gecerli_o = yanit_aktif & sahip
                            & anabellek_yanit_gecerli_i;

  // Data goes to both ports; only the owner sees valid.
  assign p0_yanit_veri_o = yanit_aktif ? anabellek_yanit_veri_i
                                       : '0;
  assign p1_yanit_veri_o = yanit_aktif ? anabellek_yanit_veri_i
                                       : '0;

endmodule
